// File: rtl/tcdm_bus_36_rr_arbiter_pkg.sv
// Shared widths, tag layout and request record for the DIFT-tagged 36-bit TCDM bus.
package tcdm36_pkg;

    localparam int TCDM36_DATA_W = 36;
    localparam int TCDM_ADDR_W   = 32;
    localparam int TCDM_BE_W     = 4;
    localparam int TAG_BIT_POS [4] = '{8, 17, 26, 35};

    typedef struct packed {
        logic [TCDM_ADDR_W-1:0]   add;
        logic                     wen;
        logic [TCDM_BE_W-1:0]     be;
        logic [TCDM36_DATA_W-1:0] wdata;
    } tcdm36_req_t;

    // One tag bit sits above each data byte.
    function automatic logic [3:0] tag_bits(input logic [TCDM36_DATA_W-1:0] d);
        logic [3:0] t;
        t = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            t[i] = d[TAG_BIT_POS[i]];
        end
        return t;
    endfunction

endpackage

// File: rtl/tcdm_bus_36_rr_arbiter_if.sv
// Requester-side and master-side signals of the arbiter; lock_i exists only with TCDM_ARB36_LOCK_EN.
interface tcdm_bus_36_rr_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]                                    req_i;
  logic [N_REQ-1:0][tcdm36_pkg::TCDM_ADDR_W-1:0]       add_i;
  logic [N_REQ-1:0]                                    wen_i;
  logic [N_REQ-1:0][tcdm36_pkg::TCDM_BE_W-1:0]         be_i;
  logic [N_REQ-1:0][tcdm36_pkg::TCDM36_DATA_W-1:0]     wdata_i;
  logic [N_REQ-1:0]                                    gnt_o;
  logic [N_REQ-1:0]                                    r_valid_o;
  logic                                                r_opc_o;
  logic [tcdm36_pkg::TCDM36_DATA_W-1:0]                r_rdata_o;
  logic                                                m_req_o;
  logic [tcdm36_pkg::TCDM_ADDR_W-1:0]                  m_add_o;
  logic                                                m_wen_o;
  logic [tcdm36_pkg::TCDM_BE_W-1:0]                    m_be_o;
  logic [tcdm36_pkg::TCDM36_DATA_W-1:0]                m_wdata_o;
  logic                                                m_gnt_i;
  logic                                                m_r_valid_i;
  logic                                                m_r_opc_i;
  logic [tcdm36_pkg::TCDM36_DATA_W-1:0]                m_r_rdata_i;
`ifdef TCDM_ARB36_LOCK_EN
  logic [N_REQ-1:0]                                    lock_i;

  modport slave (
    input  req_i, add_i, wen_i, be_i, wdata_i, lock_i,
    output gnt_o, r_valid_o, r_opc_o, r_rdata_o,
    output m_req_o, m_add_o, m_wen_o, m_be_o, m_wdata_o,
    input  m_gnt_i, m_r_valid_i, m_r_opc_i, m_r_rdata_i
  );

  modport master (
    output req_i, add_i, wen_i, be_i, wdata_i, lock_i,
    input  gnt_o, r_valid_o, r_opc_o, r_rdata_o,
    input  m_req_o, m_add_o, m_wen_o, m_be_o, m_wdata_o,
    output m_gnt_i, m_r_valid_i, m_r_opc_i, m_r_rdata_i
  );
`else
  modport slave (
    input  req_i, add_i, wen_i, be_i, wdata_i,
    output gnt_o, r_valid_o, r_opc_o, r_rdata_o,
    output m_req_o, m_add_o, m_wen_o, m_be_o, m_wdata_o,
    input  m_gnt_i, m_r_valid_i, m_r_opc_i, m_r_rdata_i
  );

  modport master (
    output req_i, add_i, wen_i, be_i, wdata_i,
    input  gnt_o, r_valid_o, r_opc_o, r_rdata_o,
    input  m_req_o, m_add_o, m_wen_o, m_be_o, m_wdata_o,
    output m_gnt_i, m_r_valid_i, m_r_opc_i, m_r_rdata_i
  );
`endif
endinterface

// File: rtl/tcdm_bus_36_rr_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions; push and pop may share a cycle.
module tcdm_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [ID_W-1:0] id_i,
  input  logic            pop_i,
  output logic [ID_W-1:0] head_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == {CNT_W{1'b0}});
  assign head_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {ID_W{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= id_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/tcdm_bus_36_rr_arbiter.sv
// Round-robin arbiter of N_REQ tagged TCDM requesters onto one master port, responses routed by ID FIFO.
// Define TCDM_ARB36_LOCK_EN to add lock_i, which lets a granted requester retain priority.
module tcdm_bus_36_rr_arbiter
  import tcdm36_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  tcdm_bus_36_rr_arbiter_if.slave bus,
  output logic                    err_o
);
  localparam int              ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] winner_s, head_s;
  logic            found_s, lock_s;
  logic            m_req_s, hs_s, pop_s;
  logic            full_s, empty_s;
  logic            err_q, err_d;
  tcdm36_req_t     win_req_s;

  // First active request at or after rr_ptr_q, wrapping; idle selects requester 0.
  always_comb begin
    winner_s = {ID_W{1'b0}};
    found_s  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found_s && bus.req_i[ID_W'((int'(rr_ptr_q) + k) % N_REQ)]) begin
        winner_s = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  always_comb begin
    win_req_s.add   = bus.add_i[winner_s];
    win_req_s.wen   = bus.wen_i[winner_s];
    win_req_s.be    = bus.be_i[winner_s];
    win_req_s.wdata = bus.wdata_i[winner_s];
  end

`ifdef TCDM_ARB36_LOCK_EN
  assign lock_s = bus.lock_i[winner_s];
`else
  assign lock_s = 1'b0;
`endif

  // A full FIFO blocks requests even when it pops this cycle, so no pop-to-grant path exists.
  assign m_req_s = (|bus.req_i) & ~full_s & ~rst_i;
  assign hs_s    = m_req_s & bus.m_gnt_i;
  assign pop_s   = bus.m_r_valid_i & ~empty_s & ~rst_i;

  // Pointer moves past the winner on a handshake, or stays on it while it holds a lock.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs_s) begin
      if (lock_s) begin
        rr_ptr_d = winner_s;
      end else if (winner_s == LAST_ID) begin
        rr_ptr_d = {ID_W{1'b0}};
      end else begin
        rr_ptr_d = winner_s + ID_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  assign err_d = err_q | (bus.m_r_valid_i & empty_s);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= {ID_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  tcdm_arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs_s),
    .id_i    (winner_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  always_comb begin
    bus.gnt_o     = {N_REQ{1'b0}};
    bus.r_valid_o = {N_REQ{1'b0}};
    if (hs_s) begin
      bus.gnt_o[winner_s] = 1'b1;
    end else begin
      bus.gnt_o = {N_REQ{1'b0}};
    end
    if (pop_s) begin
      bus.r_valid_o[head_s] = 1'b1;
    end else begin
      bus.r_valid_o = {N_REQ{1'b0}};
    end
  end

  assign bus.m_req_o   = m_req_s;
  assign bus.m_add_o   = win_req_s.add;
  assign bus.m_wen_o   = win_req_s.wen;
  assign bus.m_be_o    = win_req_s.be;
  assign bus.m_wdata_o = win_req_s.wdata;
  assign bus.r_opc_o   = bus.m_r_opc_i;
  assign bus.r_rdata_o = bus.m_r_rdata_i;
  assign err_o         = err_q & ~rst_i;
endmodule
